// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: shared constants for the memory-mapped UART transmitter.
// Holds the register offsets, the STATUS bit positions, the shifter state
// encoding and the 8N1 framing constants.
package mmio_uart_tx_pkg;

    // Register offsets (bus ADDR[1:0])
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY   = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_CNT_HI = 6;

    // Shifter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // 8N1 framing
    localparam int         DATA_BITS = 8;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: bus control signals of the CPU responder bus.
//   CS   - block select, already decoded at the top level
//   WE   - 1 = write cycle, 0 = read cycle
//   ADDR - register select
// The shared Mem_Bus data lines are a tristate net and stay a direct port of
// the responder, so the drivers resolve on a single wire.
interface mmio_uart_tx_if;
    logic       CS;
    logic       WE;
    logic [1:0] ADDR;

    modport master (output CS, WE, ADDR);
    modport slave  (input  CS, WE, ADDR);
endinterface

// File: rtl/mmio_uart_tx_tx_fifo.sv
// tx_fifo: synchronous byte FIFO for the UART transmitter.
//   CLK, RST    - clock, synchronous active-high reset
//   push, din   - write request and data (accepted when not full, or when
//                 full together with a pop)
//   pop, dout   - read request and head data (dout is the current head)
//   full, empty - occupancy flags
//   count       - number of stored entries, 0..DEPTH
module tx_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a push against a full FIFO
    // is still taken when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU CS/WE/ADDR bus.
//   CLK, RST - clock, synchronous active-high reset
//   bus      - CS/WE/ADDR responder side
//   Mem_Bus  - shared data bus, driven only during selected read cycles
//   TXD      - registered serial output, idle high
//   BUSY     - frame in progress or FIFO non-empty
//
// Shifter FSM:
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | line idle (TXD=1), waiting for EN and a queued byte
//   ST_START | start bit (TXD=0) for one bit period
//   ST_DATA  | data bits 0..7, LSB first, one bit period each
//   ST_STOP  | stop bit (TXD=1); chains straight into the next frame
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RST    = 16'd867
) (
    input  logic                 CLK,
    input  logic                 RST,
    mmio_uart_tx_if.slave        bus,
    inout  wire  [31:0]          Mem_Bus,
    output logic                 TXD,
    output logic                 BUSY
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic [15:0] div_q, div_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;

    logic        wr_en, rd_en, push, pop, load, can_start, period_end;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    logic [31:0] rdata;

    assign wr_en = bus.CS && bus.WE;
    assign rd_en = bus.CS && !bus.WE;
    assign push  = wr_en && (bus.ADDR == REG_TXDATA);

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   (Mem_Bus[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign TXD  = txd_q;
    assign BUSY = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        rdata = '0;
        case (bus.ADDR)
            REG_STATUS: rdata = {25'b0, 3'(fifo_count), ovf_q, fifo_empty, fifo_full, BUSY};
            REG_DIV:    rdata = {16'b0, div_q};
            REG_CTRL:   rdata = {31'b0, en_q};
            default:    rdata = '0;
        endcase
    end

    assign Mem_Bus = rd_en ? rdata : 32'bz;

    always_comb begin
        div_d = div_q;
        en_d  = en_q;
        ovf_d = ovf_q;
        if (wr_en) begin
            case (bus.ADDR)
                REG_STATUS: if (Mem_Bus[STAT_OVF]) ovf_d = 1'b0;
                REG_DIV:    div_d = Mem_Bus[15:0];
                REG_CTRL:   en_d  = Mem_Bus[0];
                default:    ;
            endcase
        end
        // A push that meets a pop is taken, so only an unpaired full push drops.
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    assign can_start  = en_q && !fifo_empty;
    assign period_end = (div_cnt_q == div_lat_q);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        div_lat_d = div_lat_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: load = can_start;
            ST_START: begin
                if (period_end) begin
                    state_d   = ST_DATA;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (period_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (period_end) begin
                    if (can_start) load    = 1'b1;
                    else           state_d = ST_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Frame start: the divisor is sampled here so later DIV writes only
        // affect the following frame.
        if (load) begin
            state_d   = ST_START;
            shift_d   = fifo_dout;
            div_lat_d = div_q;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            txd_d     = 1'b0;
        end
    end

    assign pop = load;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            div_lat_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            div_q     <= DIV_RST;
            en_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            div_lat_q <= div_lat_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            div_q     <= div_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed + randomized bench for mmio_uart_tx. Expected TXD
// and BUSY traces are built per cycle from the 8N1 framing rules and compared
// against a trace recorded one time unit after every rising edge.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    wire  [31:0] mem_bus;
    logic [31:0] drv_data;
    logic        drv_en;
    logic        TXD, BUSY;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx_if bus_if ();

    assign mem_bus = drv_en ? drv_data : 32'bz;

    mmio_uart_tx #(.FIFO_DEPTH(4), .DIV_RST(16'd867)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus_if),
        .Mem_Bus (mem_bus),
        .TXD     (TXD),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    logic rec_on = 1'b0;
    logic log_txd[$];
    logic log_busy[$];
    logic exp_txd[$];
    logic exp_busy[$];

    always @(posedge CLK) begin
        #1;
        if (rec_on) begin
            log_txd.push_back(TXD);
            log_busy.push_back(BUSY);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.CS = 1'b1; bus_if.WE = 1'b1; bus_if.ADDR = a;
        drv_data = d; drv_en = 1'b1;
        @(negedge CLK);
        bus_if.CS = 1'b0; bus_if.WE = 1'b0; drv_en = 1'b0;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus_if.CS = 1'b1; bus_if.WE = 1'b0; bus_if.ADDR = a; drv_en = 1'b0;
        #2;
        d = mem_bus;
        @(negedge CLK);
        bus_if.CS = 1'b0;
        check(tag, d, exp);
    endtask

    function automatic logic [31:0] status_word(input int cnt, input logic ovf,
                                                input logic busy);
        logic [2:0] c;
        c = 3'(cnt);
        return {25'b0, c, ovf, (cnt == 0), (cnt == 4), busy};
    endfunction

    // First recorded sample follows the write edge: line still idle, FIFO busy.
    task automatic model_begin();
        exp_txd.delete(); exp_busy.delete();
        exp_txd.push_back(1'b1); exp_busy.push_back(1'b1);
    endtask

    task automatic model_frame(input logic [7:0] data, input int d);
        for (int b = 0; b < 10; b++) begin
            logic v;
            v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b-1];
            for (int c = 0; c <= d; c++) begin
                exp_txd.push_back(v); exp_busy.push_back(1'b1);
            end
        end
    endtask

    task automatic model_end(input int n);
        for (int i = 0; i < n; i++) begin
            exp_txd.push_back(1'b1); exp_busy.push_back(1'b0);
        end
    endtask

    task automatic start_rec();
        log_txd.delete(); log_busy.delete();
        rec_on = 1'b1;
    endtask

    task automatic compare_log(input string tag);
        int budget;
        budget = exp_txd.size() + 20;
        while (log_txd.size() < exp_txd.size() && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        #2;
        rec_on = 1'b0;
        check({tag, " trace length reached"}, 32'(log_txd.size() >= exp_txd.size()), 32'd1);
        for (int i = 0; i < exp_txd.size() && i < log_txd.size(); i++) begin
            check($sformatf("%s txd[%0d]", tag, i), 32'(log_txd[i]), 32'(exp_txd[i]));
            check($sformatf("%s busy[%0d]", tag, i), 32'(log_busy[i]), 32'(exp_busy[i]));
        end
        @(negedge CLK);
    endtask

    task automatic watch_idle(input int n, input string tag);
        int zeros;
        zeros = 0;
        for (int i = 0; i < n; i++) begin
            if (TXD !== 1'b1) zeros++;
            @(negedge CLK);
        end
        check(tag, zeros, 0);
    endtask

    initial begin
        logic [7:0] b [6];
        int         nd, n;

        RST = 1'b1;
        bus_if.CS = 1'b0; bus_if.WE = 1'b0; bus_if.ADDR = 2'd0;
        drv_data = '0; drv_en = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Reset state
        check("reset txd", 32'(TXD), 32'd1);
        check("reset busy", 32'(BUSY), 32'd0);
        read_check(REG_STATUS, 32'h0000_0004, "reset status");
        read_check(REG_DIV, 32'd867, "reset div");
        read_check(REG_CTRL, 32'd1, "reset ctrl");
        read_check(REG_TXDATA, 32'd0, "txdata reads zero");

        // A write with CS=0 is ignored
        bus_if.CS = 1'b0; bus_if.WE = 1'b1; bus_if.ADDR = REG_DIV;
        drv_data = 32'h0000_1234; drv_en = 1'b1;
        @(negedge CLK);
        bus_if.WE = 1'b0; drv_en = 1'b0;
        read_check(REG_DIV, 32'd867, "cs0 write ignored");

        // Single frame 0xA5 at DIV=3
        bus_write(REG_DIV, 32'd3);
        read_check(REG_DIV, 32'd3, "div readback");
        model_begin(); model_frame(8'hA5, 3); model_end(3);
        start_rec();
        bus_write(REG_TXDATA, 32'h0000_00A5);
        compare_log("frame_a5");
        read_check(REG_STATUS, status_word(0, 1'b0, 1'b0), "status after a5");

        // Back-to-back: 5 queued, 6th overflows and is dropped
        model_begin();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) model_frame(b[i], 3);
        model_end(3);
        start_rec();
        for (int i = 0; i < 6; i++) bus_write(REG_TXDATA, {24'h0, b[i]});
        read_check(REG_STATUS, status_word(4, 1'b1, 1'b1), "status full+ovf");
        bus_write(REG_STATUS, 32'h0000_0008);
        read_check(REG_STATUS, status_word(4, 1'b0, 1'b1), "status ovf cleared");
        compare_log("b2b");

        // EN=0 holds the byte; EN=1 starts it on the next edge
        bus_write(REG_CTRL, 32'd0);
        bus_write(REG_TXDATA, 32'h0000_003C);
        watch_idle(8, "en0 line idle");
        read_check(REG_STATUS, status_word(1, 1'b0, 1'b1), "en0 status");
        read_check(REG_CTRL, 32'd0, "ctrl readback");
        model_begin(); model_frame(8'h3C, 3); model_end(3);
        start_rec();
        bus_write(REG_CTRL, 32'd1);
        compare_log("en_resume");

        // DIV changed mid-frame affects the next frame only
        nd = int'($urandom_range(0, 2));
        b[0] = 8'($urandom); b[1] = 8'($urandom);
        model_begin(); model_frame(b[0], 3); model_frame(b[1], nd); model_end(3);
        start_rec();
        bus_write(REG_TXDATA, {24'h0, b[0]});
        bus_write(REG_TXDATA, {24'h0, b[1]});
        repeat (5) @(negedge CLK);
        bus_write(REG_DIV, 32'(nd));
        compare_log("div_midframe");

        // DIV=0: one clock per bit
        bus_write(REG_DIV, 32'd0);
        b[0] = 8'($urandom); b[1] = 8'($urandom);
        model_begin(); model_frame(b[0], 0); model_frame(b[1], 0); model_end(3);
        start_rec();
        bus_write(REG_TXDATA, {24'h0, b[0]});
        bus_write(REG_TXDATA, {24'h0, b[1]});
        compare_log("div0");

        // Random divisor and burst length
        for (int t = 0; t < 3; t++) begin
            nd = int'($urandom_range(0, 6));
            n  = int'($urandom_range(1, 4));
            bus_write(REG_DIV, 32'(nd));
            model_begin();
            for (int i = 0; i < n; i++) begin
                b[i] = 8'($urandom);
                model_frame(b[i], nd);
            end
            model_end(3);
            start_rec();
            for (int i = 0; i < n; i++) bus_write(REG_TXDATA, {24'h0, b[i]});
            compare_log($sformatf("rand%0d", t));
        end

        // Reset during the data phase aborts the frame and flushes the FIFO
        bus_write(REG_DIV, 32'd3);
        for (int i = 0; i < 3; i++) bus_write(REG_TXDATA, 32'(8'h00 + i));
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("rst txd", 32'(TXD), 32'd1);
        check("rst busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        read_check(REG_STATUS, 32'h0000_0004, "status after rst");
        read_check(REG_DIV, 32'd867, "div after rst");
        watch_idle(60, "no frames after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that answers the CPU's single-cycle CS/WE/ADDR/Mem_Bus bus as a responder, alongside the RAM. The top level decodes its address window and drives CS. Software writes bytes into a small FIFO, and the block serialises them on TXD as 8N1 frames at a programmable bit period. Status and configuration are readable over the same bus with zero wait states.

## Interface
- FIFO_DEPTH, 4: TX FIFO entries; power of two, ≥2.
- DIV_RST, 16'd867: reset value of the bit-period divisor.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- CS  in  1  block select, already address-decoded at top level.
- WE  in  1  1 = write cycle, 0 = read cycle; meaningful only with CS=1.
- ADDR  in  2  register select, from bus ADDR[1:0].
- Mem_Bus  inout  32  shared data bus; driven only when CS=1 and WE=0, else 32'bZ.
- TXD  out  1  serial output, idle high.
- BUSY  out  1  1 while a frame is shifting or the FIFO is non-empty.

## Operation
- Register map (ADDR):
  - 0 TXDATA: a write pushes Mem_Bus[7:0]. If the FIFO is full, the write is dropped and sticky OVF is set. Reads return 0.
  - 1 STATUS: reads {25'b0, count[2:0], OVF, EMPTY, FULL, BUSY} in bits [31:0], with BUSY at bit 0, FULL at bit 1, EMPTY at bit 2, OVF at bit 3, count at bits 6:4. A write with bit3=1 clears OVF; other bits are ignored.
  - 2 DIV: bits[15:0], R/W. Bit period = DIV+1 clocks. The shifter latches DIV at each frame start, so a write mid-frame affects the next frame only.
  - 3 CTRL: bit0 EN, R/W. EN=0 prevents new frames from starting; a frame in progress completes.
- Reads are combinational from registers, with no side effects.
- Frame: start bit 0, then data bits 0..7 LSB first, then stop bit 1. TXD is registered.
- FSM states and transitions:
  - IDLE → START when EN=1 and FIFO non-empty. Pop the head, load the shift register, latch the divisor, TXD←0.
  - START → DATA after DIV+1 cycles. TXD←bit0.
  - DATA advances one bit every DIV+1 cycles. After bit7's period, → STOP with TXD←1.
  - STOP, after DIV+1 cycles: → START directly (pop, no idle gap) if EN=1 and FIFO non-empty; otherwise → IDLE.
- Bit counter is 3 bits. The divisor counter is 16 bits, counts up from 0, and the period ends at count==latched DIV.
- DIV=0 is legal and gives 1 clock per bit.
- Simultaneous push and pop: when full, the push is accepted and count is unchanged. When empty, there is no bypass: the push lands first and the pop happens on a later cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

## Timing
- Reset values: TXD=1, BUSY=0, Mem_Bus=Z, FIFO empty, OVF=0, DIV=DIV_RST, EN=1, FSM=IDLE.
- RST mid-frame: TXD is 1 on the clock after the reset edge, the frame is aborted, and the FIFO contents are discarded.
- Write latency: the write is captured on the rising edge ending the CS=1, WE=1 cycle.
- Read latency: data is valid within the same cycle CS=1, WE=0, before the next rising edge.
- Start latency: a TXDATA write at edge k into an empty FIFO in IDLE with EN=1 gives TXD falling at edge k+1.
- Frame length: exactly 10×(DIV+1) clocks. Back-to-back frames have no gap.
- BUSY falls on the edge where STOP → IDLE.
- Write with CS=0 has no effect.

## Structure
- Shared package holds:
  - register offsets (TXDATA, STATUS, DIV, CTRL);
  - STATUS bit positions;
  - FSM state encoding (IDLE, START, DATA, STOP, 2 bits);
  - 8N1 constants (data bits = 8).
- One sub-module: tx_fifo, a synchronous FIFO with 8-bit data, push/pop/full/empty/count, parameterised depth.
- The top of mmio_uart_tx contains the bus decode, registers and shifter FSM.

## Test plan
- Reset then read STATUS: returns 32'h0000_0004 (EMPTY only), TXD=1, and a DIV read returns 867.
- DIV=3, write TXDATA=0xA5: TXD sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks, total 40 clocks, then BUSY=0.
- DIV=3, write 5 bytes back to back without waiting: the first is popped into the shifter, the next 4 fill the FIFO, and no OVF. A 6th write lands while full → OVF=1 and the byte is dropped. The four queued frames then follow with no idle gap. Writing STATUS=8 clears OVF.
- EN=0, write 0x3C: TXD stays 1 and STATUS shows count=1. Set EN=1: TXD falls on the following edge.
- Mid-frame DIV change: the current frame keeps its old 4-clock bits and the next frame uses the new period.
- Assert RST during the DATA phase: TXD=1 next clock, the FIFO is empty, and no further frames are emitted.
